arb_mux_nto1: RTL
=================

// Module: arb_mux_nto1
// PURPOSE
//  Parametrised N-to-1 registered data mux with per-channel valid/ready handshake and
//  built-in arbitration (round-robin or fixed priority). Successor to the 2:1 combinational
//  mux. Used where several pipeline sources compete for one sink, e.g. a shared
//  write-back/debug port. One output register stage gives 1-cycle latency at full throughput.
// PARAMETERS
//  NB_DATA   32                      data width per channel
//  N_CH      4                       number of input channels (>=2)
//  NB_SEL    $clog2(N_CH)            channel-index width (derived, not overridden)
//  ARB_MODE  0                       0 = round-robin, 1 = fixed priority (lowest index wins)
// PORTS
//  i_clk     in   1                  clock, rising edge
//  i_rst     in   1                  synchronous reset, active high
//  i_data    in   N_CH*NB_DATA       flattened inputs; channel k = i_data[k*NB_DATA +: NB_DATA]
//  i_valid   in   N_CH               channel k holds a beat
//  o_ready   out  N_CH               channel k beat accepted this cycle (one-hot or zero)
//  o_data    out  NB_DATA            registered selected data
//  o_sel     out  NB_SEL             index of channel that produced o_data
//  o_valid   out  1                  o_data/o_sel valid
//  i_ready   in   1                  sink accepts o_data this cycle
// BEHAVIOUR
//  - Reset (i_rst=1 at edge): o_valid=0, o_data=0, o_sel=0, RR pointer=0. Any held beat is
//    dropped. While i_rst=1, o_ready is all zero.
//  - load_en = ~o_valid | i_ready (output reg empty, or being drained this cycle).
//  - grant: one-hot over i_valid by ARB_MODE; zero when i_valid==0.
//  - o_ready = grant & {N_CH{load_en}}. This is combinational from i_valid, i_ready and state,
//    with no dependency on i_data.
//  - Transfer on channel k: i_valid[k] & o_ready[k]. At that edge: o_data<=data[k], o_sel<=k,
//    o_valid<=1.
//  - Output consumed (o_valid & i_ready) with no new grant: o_valid<=0. o_data/o_sel hold
//    their last value.
//  - Simultaneous consume and new grant: both occur in the same cycle, so there are no
//    bubbles (1 beat/cycle).
//  - Stall (o_valid & ~i_ready): o_data/o_sel/o_valid stable, o_ready all zero, pointer
//    unchanged.
//  - Round-robin: search starts at pointer p and wraps modulo N_CH. After a grant to k,
//    p <= (k==N_CH-1) ? 0 : k+1. With no grant, p is unchanged.
//  - Fixed priority: lowest set index of i_valid wins. The pointer register is unused, held
//    at 0.
//  - Sources must hold i_valid/i_data until accepted. The block does not check this.
//  - Latency: accepted at edge n, visible on o_data after edge n.
// STRUCTURE
//  - Header arb_mux_defs.vh: ARB_RR=0, ARB_FIXED=1 constants. Also a CLOG2 helper if the
//    tool needs one.
//  - Sub-module rr_arbiter (i_clk, i_rst, i_req[N_CH], i_adv, o_gnt[N_CH], o_gnt_idx),
//    where i_adv = load_en:
//      - holds the pointer and does the wrap-around search;
//      - takes ARB_MODE so that fixed-priority mode is a parameter of the same arbiter.
//  - Top level: load_en logic, flattened-data index mux (for loop), output register.
// TESTING
//  1. Reset: drive i_valid=4'b1111 and i_rst=1 for 2 cycles. Expect o_valid=0, o_data=0,
//     o_ready=0. After i_rst falls, the first grant is ch0.
//  2. RR fairness: N_CH=4, all valid, i_ready=1, data[k]=32'hA0+k. Expect o_sel sequence
//     0,1,2,3,0,... and o_data A0,A1,A2,A3,A0. o_valid stays 1 every cycle after the first.
//  3. Wrap/skip: pointer at 3, i_valid=4'b0101. Expect grant ch0, then ch2, then ch0.
//     Ch1 and ch3 are never granted.
//  4. Backpressure: o_valid=1, o_sel=2, i_ready=0 for 3 cycles with all valid. Expect
//     o_ready=0 and o_data/o_sel frozen. On i_ready=1, a new beat (ch3) loads in the
//     same cycle.
//  5. Fixed priority: ARB_MODE=1, i_valid=4'b1110 held. Expect ch1 granted every cycle.
//     After ch1 drops, ch2 is granted.
//  6. Reset mid-stall: o_valid=1, i_ready=0, then i_rst=1 for 1 cycle. Expect o_valid=0
//     next cycle and pointer back to 0, so ch0 wins first afterwards.

Source files
------------

// File: rtl/arb_mux_nto1_pkg.sv
// Shared constants for the N-to-1 arbitrated mux: arbitration mode encodings.
package arb_mux_nto1_pkg;

   // Arbitration modes selectable through the ARB_MODE parameter
   localparam int ARB_RR    = 0;   // round-robin, search starts at the rotating pointer
   localparam int ARB_FIXED = 1;   // fixed priority, lowest channel index wins

endpackage

// File: rtl/arb_mux_nto1_rr_arbiter.sv
// Request arbiter for arb_mux_nto1. Holds the round-robin pointer and performs the
// wrap-around search; in fixed-priority mode the search always starts at channel 0
// and the pointer stays at 0.
module arb_mux_nto1_rr_arbiter
   import arb_mux_nto1_pkg::*;
#(
   parameter  int N_CH     = 4,
   parameter  int ARB_MODE = ARB_RR,
   localparam int NB_SEL   = $clog2(N_CH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [N_CH-1:0]   i_req,
   input  logic              i_adv,
   output logic [N_CH-1:0]   o_gnt,
   output logic [NB_SEL-1:0] o_gnt_idx
);

   logic [NB_SEL-1:0] ptr_reg;
   logic [NB_SEL-1:0] ptr_next;
   logic [NB_SEL-1:0] start_sel;
   logic [N_CH-1:0]   req_rot;
   logic              found;
   logic [NB_SEL-1:0] gnt_idx;
   int                sum;

   // Search origin: rotating pointer for round-robin, channel 0 for fixed priority
   assign start_sel = (ARB_MODE == ARB_FIXED) ? '0 : ptr_reg;

   // Rotate requests so the search origin sits at bit 0, take the first set bit and
   // map its offset back to an absolute channel index modulo N_CH
   always_comb begin
      req_rot = N_CH'({i_req, i_req} >> start_sel);
      found   = 1'b0;
      gnt_idx = '0;
      sum     = 0;
      for (int off = 0; off < N_CH; off++) begin
         if (!found && req_rot[off]) begin
            found = 1'b1;
            sum   = int'(start_sel) + off;
            if (sum >= N_CH) begin
               sum = sum - N_CH;
            end
            gnt_idx = NB_SEL'(sum);
         end
      end
   end

   // One-hot grant decoded from the winning index; zero when nothing requests
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_gnt
         assign o_gnt[gi] = found && (gnt_idx == NB_SEL'(gi));
      end
   endgenerate

   assign o_gnt_idx = gnt_idx;

   // Pointer moves past the winner only when the grant is actually taken
   always_comb begin
      ptr_next = ptr_reg;
      if ((ARB_MODE == ARB_RR) && i_adv && found) begin
         ptr_next = (gnt_idx == NB_SEL'(N_CH - 1)) ? '0 : gnt_idx + NB_SEL'(1);
      end
   end

   // Pointer register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/arb_mux_nto1.sv
// N-to-1 registered data mux with per-channel valid/ready and built-in arbitration.
// One output register gives 1-cycle latency; a beat can load in the same cycle the
// previous one drains, so throughput is one beat per cycle.
module arb_mux_nto1
   import arb_mux_nto1_pkg::*;
#(
   parameter  int NB_DATA  = 32,
   parameter  int N_CH     = 4,
   parameter  int ARB_MODE = ARB_RR,
   localparam int NB_SEL   = $clog2(N_CH)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [N_CH*NB_DATA-1:0] i_data,
   input  logic [N_CH-1:0]         i_valid,
   output logic [N_CH-1:0]         o_ready,
   output logic [NB_DATA-1:0]      o_data,
   output logic [NB_SEL-1:0]       o_sel,
   output logic                    o_valid,
   input  logic                    i_ready
);

   logic                load_en;
   logic [N_CH-1:0]     gnt;
   logic [NB_SEL-1:0]   gnt_idx;
   logic                transfer;
   logic [NB_DATA-1:0]  mux_data;
   logic [NB_DATA-1:0]  data_reg;
   logic [NB_SEL-1:0]   sel_reg;
   logic                valid_reg;

   // Output register can take a new beat when empty or being drained this cycle
   assign load_en = ~valid_reg | i_ready;

   arb_mux_nto1_rr_arbiter #(
      .N_CH     (N_CH),
      .ARB_MODE (ARB_MODE)
   ) u_arbiter (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_req     (i_valid),
      .i_adv     (load_en),
      .o_gnt     (gnt),
      .o_gnt_idx (gnt_idx)
   );

   // Accept strobes: grant qualified by load_en, forced low while in reset
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
         assign o_ready[gi] = gnt[gi] & load_en & ~i_rst;
      end
   endgenerate

   // Grant implies valid, so any accept strobe is a transfer
   assign transfer = |o_ready;

   // Select the granted channel's slice out of the flattened data bus
   always_comb begin
      mux_data = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (gnt_idx == NB_SEL'(k)) begin
            mux_data = i_data[k*NB_DATA +: NB_DATA];
         end
      end
   end

   // Output register: load on transfer, clear valid on drain, otherwise hold
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
         sel_reg   <= '0;
      end else if (transfer) begin
         valid_reg <= 1'b1;
         data_reg  <= mux_data;
         sel_reg   <= gnt_idx;
      end else if (i_ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign o_data  = data_reg;
   assign o_sel   = sel_reg;
   assign o_valid = valid_reg;

endmodule
